// File: rtl/swap_datapath_pkg.sv
// Shared constants for the three-register swap datapath: load-select
// codes and the bit positions of the h (out) / c (in) strobes.
package swap_datapath_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int NUM_REGS  = 3;

  typedef enum logic [1:0] {
    REG_R1   = 2'd0,
    REG_R2   = 2'd1,
    REG_R3   = 2'd2,
    REG_NONE = 2'd3
  } reg_sel_e;

  // h1..h3 drive out_en, c1..c3 drive in_en; same bit index per register
  localparam int H1_BIT = 0;
  localparam int H2_BIT = 1;
  localparam int H3_BIT = 2;
  localparam int C1_BIT = 0;
  localparam int C2_BIT = 1;
  localparam int C3_BIT = 2;

endpackage

// File: rtl/swap_datapath_bus_src_mux.sv
// Bus source selection: picks the single enabled register, the host load
// value when nothing drives the bus, or zero; flags single and multi drive.
module swap_datapath_bus_src_mux
  import swap_datapath_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       out_en,
  input  logic             ld_en,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] bus,
  output logic             one_hot,
  output logic             multi_drive
);

  always_comb begin
    bus         = '0;
    one_hot     = 1'b0;
    multi_drive = 1'b0;
    case (out_en)
      3'b000: begin
        if (ld_en) bus = ld_data;
      end
      3'b001: begin
        bus     = r1;
        one_hot = 1'b1;
      end
      3'b010: begin
        bus     = r2;
        one_hot = 1'b1;
      end
      3'b100: begin
        bus     = r3;
        one_hot = 1'b1;
      end
      default: multi_drive = 1'b1;
    endcase
  end

endmodule

// File: rtl/swap_datapath.sv
// Three-register shared-bus datapath: one transfer per clock, host preload,
// contention/drop flags, saturating transfer count and a done result strobe.
module swap_datapath
  import swap_datapath_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       out_en,
  input  logic [2:0]       in_en,
  input  logic             done_in,
  input  logic             clr,
  input  logic             ld_en,
  input  logic [1:0]       ld_sel,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             conflict,
  output logic             ld_drop,
  output logic             result_valid
);

  logic [WIDTH-1:0] r_q [NUM_REGS];
  logic [WIDTH-1:0] r_d [NUM_REGS];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             conflict_q, conflict_d;
  logic             ld_drop_q, ld_drop_d;
  logic             done_d_q;
  logic             result_valid_q;

  logic one_hot;
  logic multi_drive;
  logic xfer;
  logic strobes_any;
  logic load_ok;
  logic load_drop;

  swap_datapath_bus_src_mux #(.WIDTH(WIDTH)) u_bus_src_mux (
    .out_en      (out_en),
    .ld_en       (ld_en),
    .ld_data     (ld_data),
    .r1          (r_q[0]),
    .r2          (r_q[1]),
    .r3          (r_q[2]),
    .bus         (bus),
    .one_hot     (one_hot),
    .multi_drive (multi_drive)
  );

  assign strobes_any = (out_en != 3'b000) || (in_en != 3'b000);
  assign xfer        = one_hot && (in_en != 3'b000);
  assign load_ok     = ld_en && !strobes_any && (ld_sel != REG_NONE);
  // A select of "none" is a no-op even when strobes are active
  assign load_drop   = ld_en && strobes_any && (ld_sel != REG_NONE);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      r_d[i] = r_q[i];
      if (one_hot && in_en[i]) begin
        r_d[i] = bus;
      end else if (load_ok && (ld_sel == 2'(i))) begin
        r_d[i] = ld_data;
      end
    end

    cnt_d      = cnt_q;
    conflict_d = conflict_q;
    ld_drop_d  = ld_drop_q;
    if (clr) begin
      cnt_d      = '0;
      conflict_d = 1'b0;
      ld_drop_d  = 1'b0;
    end else begin
      if (xfer && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
      if (multi_drive) conflict_d = 1'b1;
      if (load_drop)   ld_drop_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_q[i] <= '0;
      cnt_q          <= '0;
      conflict_q     <= 1'b0;
      ld_drop_q      <= 1'b0;
      done_d_q       <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) r_q[i] <= r_d[i];
      cnt_q          <= cnt_d;
      conflict_q     <= conflict_d;
      ld_drop_q      <= ld_drop_d;
      done_d_q       <= done_in;
      result_valid_q <= done_in && !done_d_q;
    end
  end

  assign r1           = r_q[0];
  assign r2           = r_q[1];
  assign r3           = r_q[2];
  assign xfer_cnt     = cnt_q;
  assign conflict     = conflict_q;
  assign ld_drop      = ld_drop_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_swap_datapath.sv
// Directed bench for swap_datapath: swap sequence, contention, load collision,
// counter saturation (second instance with CNT_W=2), held done and mid-run reset.
module tb_swap_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] out_en, in_en;
  logic       done_in, clr, ld_en;
  logic [1:0] ld_sel;
  logic [7:0] ld_data;

  logic [7:0] bus, r1, r2, r3;
  logic [7:0] xfer_cnt;
  logic       conflict, ld_drop, result_valid;

  logic [7:0] bus_s, r1_s, r2_s, r3_s;
  logic [1:0] xfer_cnt_s;
  logic       conflict_s, ld_drop_s, result_valid_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  swap_datapath #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .out_en(out_en), .in_en(in_en), .done_in(done_in),
    .clr(clr), .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
    .bus(bus), .r1(r1), .r2(r2), .r3(r3), .xfer_cnt(xfer_cnt),
    .conflict(conflict), .ld_drop(ld_drop), .result_valid(result_valid)
  );

  swap_datapath #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .out_en(out_en), .in_en(in_en), .done_in(done_in),
    .clr(clr), .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
    .bus(bus_s), .r1(r1_s), .r2(r2_s), .r3(r3_s), .xfer_cnt(xfer_cnt_s),
    .conflict(conflict_s), .ld_drop(ld_drop_s), .result_valid(result_valid_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    out_en = 3'b000; in_en = 3'b000; ld_en = 1'b0; ld_sel = 2'd3;
    ld_data = 8'h00; clr = 1'b0;
  endtask

  task automatic host_load(input logic [1:0] sel, input logic [7:0] data);
    out_en = 3'b000; in_en = 3'b000;
    ld_en = 1'b1; ld_sel = sel; ld_data = data;
    step();
    ld_en = 1'b0; ld_sel = 2'd3;
  endtask

  initial begin
    idle();
    done_in = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    check("rst_r1", r1, 8'h00);
    check("rst_r2", r2, 8'h00);
    check("rst_r3", r3, 8'h00);
    check("rst_cnt", xfer_cnt, 8'h00);
    check("rst_conflict", conflict, 1'b0);
    check("rst_ld_drop", ld_drop, 1'b0);
    check("rst_rv", result_valid, 1'b0);

    // Full swap R1<->R2 via R3
    host_load(2'd0, 8'h3C);
    host_load(2'd1, 8'hA5);
    check("load_r1", r1, 8'h3C);
    check("load_r2", r2, 8'hA5);
    out_en = 3'b010; in_en = 3'b100;
    #1 check("swap1_bus", bus, 8'hA5);
    step();
    check("swap1_r3", r3, 8'hA5);
    out_en = 3'b001; in_en = 3'b010;
    step();
    check("swap2_r2", r2, 8'h3C);
    out_en = 3'b100; in_en = 3'b001; done_in = 1'b1;
    step();
    check("swap_r1", r1, 8'hA5);
    check("swap_r2", r2, 8'h3C);
    check("swap_r3", r3, 8'hA5);
    check("swap_cnt", xfer_cnt, 8'd3);
    check("swap_rv", result_valid, 1'b1);
    check("swap_conflict", conflict, 1'b0);
    idle(); done_in = 1'b0;
    step();
    check("swap_rv_one", result_valid, 1'b0);

    // Contention
    host_load(2'd0, 8'h11);
    host_load(2'd1, 8'h22);
    out_en = 3'b011; in_en = 3'b100;
    #1 check("cont_bus", bus, 8'h00);
    step();
    check("cont_r3", r3, 8'hA5);
    check("cont_flag", conflict, 1'b1);
    check("cont_cnt", xfer_cnt, 8'd3);
    idle();
    step();
    check("cont_held", conflict, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_conflict", conflict, 1'b0);
    check("clr_cnt", xfer_cnt, 8'd0);
    check("clr_regs", r1, 8'h11);

    // Load collision: strobes win, load dropped
    host_load(2'd1, 8'h5A);
    out_en = 3'b010; in_en = 3'b001;
    ld_en = 1'b1; ld_sel = 2'd0; ld_data = 8'hFF;
    step();
    check("coll_r1", r1, 8'h5A);
    check("coll_drop", ld_drop, 1'b1);
    check("coll_cnt", xfer_cnt, 8'd1);
    idle();
    step();
    check("drop_sticky", ld_drop, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_drop", ld_drop, 1'b0);

    // ld_sel=3 no-op; in_en without a driver does nothing
    ld_en = 1'b1; ld_sel = 2'd3; ld_data = 8'hEE;
    step();
    check("none_drop", ld_drop, 1'b0);
    check("none_r3", r3, 8'hA5);
    idle();
    in_en = 3'b001;
    step();
    check("nodrv_r1", r1, 8'h5A);
    check("nodrv_cnt", xfer_cnt, 8'd0);
    idle();

    // Saturation: self-transfers R1->R1
    out_en = 3'b001; in_en = 3'b001;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("sat_cnt8", xfer_cnt, 32'(i));
      check("sat_cnt2", xfer_cnt_s, (i > 3) ? 32'd3 : 32'(i));
    end
    check("self_r1", r1, 8'h5A);
    idle();

    // Done held for four cycles
    done_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_rv", result_valid, (i == 0) ? 1'b1 : 1'b0);
    end
    done_in = 1'b0;
    step();
    check("hold_rv_end", result_valid, 1'b0);

    // Reset during step 2 of a swap
    host_load(2'd0, 8'h3C);
    host_load(2'd1, 8'hA5);
    out_en = 3'b010; in_en = 3'b100;
    step();
    out_en = 3'b001; in_en = 3'b010; done_in = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; idle(); done_in = 1'b0;
    check("mrst_r1", r1, 8'h00);
    check("mrst_r2", r2, 8'h00);
    check("mrst_r3", r3, 8'h00);
    check("mrst_cnt", xfer_cnt, 8'h00);
    check("mrst_conflict", conflict, 1'b0);
    check("mrst_drop", ld_drop, 1'b0);
    check("mrst_rv", result_valid, 1'b0);
    step();
    check("mrst_rv_next", result_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
